// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-addressed data memory unit.
// Request sizes, FSM states and size-to-byte-count decoding live here.
package mem_pkg;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_RSV} mem_size_t;
  typedef enum logic {ST_IDLE, ST_BEAT2} mem_state_t;

  // Reserved size decodes to zero bytes so it can never write or split.
  function automatic logic [2:0] size_nbytes(input mem_size_t s);
    case (s)
      MEM_B:   size_nbytes = 3'd1;
      MEM_H:   size_nbytes = 3'd2;
      MEM_W:   size_nbytes = 3'd4;
      default: size_nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] size_lanes(input mem_size_t s);
    case (s)
      MEM_B:   size_lanes = 4'b0001;
      MEM_H:   size_lanes = 4'b0011;
      MEM_W:   size_lanes = 4'b1111;
      default: size_lanes = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Request/response bus between the CPU datapath and the data memory unit.
interface data_mem_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_load_extend.sv
// Selects the addressed bytes out of one or two fetched words and
// sign- or zero-extends them to a full 32-bit load result.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [63:0] i_words,
  input  logic [1:0]  i_off,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  // The high word only contributes when the access spilled past lane 3.
  assign w_shifted = 32'(i_words >> {i_off, 3'b000});

  always_comb begin
    o_data = '0;
    case (i_size)
      MEM_B:   o_data = i_unsigned ? {24'b0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      MEM_H:   o_data = i_unsigned ? {16'b0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      MEM_W:   o_data = w_shifted;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Little-endian, word-organised data memory with byte-lane writes and a
// registered read; accesses crossing a word boundary take a second beat.
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 17,
  parameter int    DATA_WIDTH = 32,
  parameter string INIT_FILE  = ""
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_unit_if.slave  bus
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  generate
    if (DATA_WIDTH != 32) begin : g_width_check
      $error("data_mem_unit supports DATA_WIDTH == 32 only");
    end
  endgenerate

  logic [31:0] r_mem [DEPTH];

  mem_state_t  r_state, w_state_next;
  mem_size_t   w_size;
  logic [1:0]  w_off;
  logic [IW-1:0] w_widx;
  logic [2:0]  w_nbytes;
  logic        w_split;
  logic [63:0] w_wshift;
  logic [7:0]  w_mask;
  logic        w_unused;

  assign w_size   = mem_size_t'(bus.req_size);
  assign w_off    = bus.req_addr[1:0];
  assign w_widx   = bus.req_addr[ADDR_WIDTH-1:2];
  assign w_nbytes = size_nbytes(w_size);
  assign w_split  = (({1'b0, w_off} + w_nbytes) > 3'd4);
  assign w_wshift = {32'b0, bus.req_wdata} << {w_off, 3'b000};
  assign w_mask   = {4'b0000, size_lanes(w_size)} << w_off;
  assign w_unused = ^bus.req_addr[DATA_WIDTH-1:ADDR_WIDTH];

  logic          r_we;
  logic [1:0]    r_off;
  mem_size_t     r_size;
  logic          r_uns;
  logic [IW-1:0] r_widx2;
  logic [31:0]   r_whi;
  logic [3:0]    r_behi;
  logic          r_rsp_valid;
  logic          r_rsp_we;
  logic          r_rsp_err;
  logic [31:0]   r_rd_lo;
  logic [31:0]   r_rd_hi;

  logic          w_ready;
  logic          w_accept;
  logic [IW-1:0] w_ram_idx;
  logic [3:0]    w_ram_be;
  logic [31:0]   w_ram_wdata;
  logic          w_rd_lo_en;
  logic          w_rd_hi_en;
  logic [31:0]   w_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // One RAM port: driven by the incoming request in IDLE, by the latched spill in BEAT2.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    w_ram_idx    = w_widx;
    w_ram_be     = 4'b0000;
    w_ram_wdata  = w_wshift[31:0];
    w_rd_lo_en   = 1'b0;
    w_rd_hi_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready  = !rst;
        w_accept = bus.req_valid && !rst;
        if (w_accept) begin
          w_rd_lo_en = !bus.req_we;
          if (bus.req_we) w_ram_be = w_mask[3:0];
          if (w_split) w_state_next = ST_BEAT2;
        end
      end
      ST_BEAT2: begin
        w_state_next = ST_IDLE;
        w_ram_idx    = r_widx2;
        w_ram_wdata  = r_whi;
        w_rd_hi_en   = !r_we;
        if (r_we) w_ram_be = r_behi;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_ram_be[b]) r_mem[w_ram_idx][8*b +: 8] <= w_ram_wdata[8*b +: 8];
    end
    if (w_rd_lo_en) r_rd_lo <= r_mem[w_ram_idx];
    if (w_rd_hi_en) r_rd_hi <= r_mem[w_ram_idx];
  end

  // Request fields are held from accept until the response has been presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_off       <= 2'b00;
      r_size      <= MEM_B;
      r_uns       <= 1'b0;
      r_widx2     <= '0;
      r_whi       <= '0;
      r_behi      <= 4'b0000;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_we        <= bus.req_we;
        r_off       <= w_off;
        r_size      <= w_size;
        r_uns       <= bus.req_unsigned;
        r_widx2     <= w_widx + IW'(1);
        r_whi       <= w_wshift[63:32];
        r_behi      <= w_mask[7:4];
        r_rsp_we    <= bus.req_we;
        r_rsp_err   <= (w_size == MEM_RSV);
        r_rsp_valid <= !w_split;
      end
      if (r_state == ST_BEAT2) r_rsp_valid <= 1'b1;
    end
  end

  mem_load_extend u_extend (
    .i_words    ({r_rd_hi, r_rd_lo}),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ext)
  );

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = (r_rsp_valid && !r_rsp_we && !r_rsp_err) ? w_ext : 32'b0;

endmodule
